// File: rtl/z80_im2_vector_ctrl.sv
// z80_im2_vector_ctrl
// Z80 interrupt-mode-2 vector controller for up to 8 prioritised channels.
// Channel 0 has the highest priority. Each channel is either falling-edge
// latched or level sensitive. The controller raises int_n toward the CPU.
// During the M1+IORQ acknowledge it drives the vector byte. It keeps
// in-service flags so that nested interrupts work; an external RETI decode
// clears those flags through eoi.
module z80_im2_vector_ctrl #(
  parameter int unsigned    NCH       = 4,
  parameter logic [7:0]     VEC_BASE  = 8'h00,
  parameter int unsigned    VEC_SHIFT = 1,
  parameter logic [NCH-1:0] EDGE_MASK = {NCH{1'b1}}
) (
  input  logic           clk_sys,
  input  logic           reset,
  input  logic [NCH-1:0] irq_n,
  input  logic           m1_n,
  input  logic           iorq_n,
  input  logic           eoi,
  input  logic           mask_we,
  input  logic [NCH-1:0] mask_din,
  output logic           int_n,
  output logic [7:0]     vec_dout,
  output logic           vec_oe,
  output logic [NCH-1:0] in_service
);

  // Width of the winning-channel index. It is kept at least 1 bit so that NCH = 1 still elaborates.
  localparam int unsigned WW = (NCH > 1) ? $clog2(NCH) : 1;

  // This index goes into the vector when an acknowledge finds nothing eligible.
  localparam logic [7:0] NONE_IDX = 8'(NCH - 1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ACK      = 2'd1,
    ST_WAIT_END = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [WW-1:0]  win_q, win_d;
  logic           win_vld_q, win_vld_d;

  logic [NCH-1:0] pend_q, pend_d;     // latched edge requests (level channels stay 0)
  logic [NCH-1:0] isr_q, isr_d;       // in-service flags
  logic [NCH-1:0] mask_q, mask_d;     // 1 = channel masked
  logic [NCH-1:0] hist_q, hist_d;     // irq_n from the previous cycle

  logic           ack;
  logic           capture;
  logic           any_eligible;
  logic [NCH-1:0] fall;
  logic [NCH-1:0] pending;
  logic [NCH-1:0] eligible;
  logic [NCH-1:0] elig_lowest;
  logic [NCH-1:0] isr_lowest;
  logic [NCH-1:0] isr_set;
  logic [WW-1:0]  elig_idx;
  logic [7:0]     win8;

  // The Z80 acknowledges an interrupt by driving M1 and IORQ low together.
  assign ack = ~m1_n & ~iorq_n;

  // Per-channel request qualification. Edge channels use the latched pending bit.
  // Level channels follow the pin directly. A channel is blocked while it or any
  // higher-priority channel is in service.
  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
      if (EDGE_MASK[gi]) begin : g_edge
        assign fall[gi]    = hist_q[gi] & ~irq_n[gi];
        assign pending[gi] = pend_q[gi];
      end else begin : g_level
        assign fall[gi]    = 1'b0;
        assign pending[gi] = ~irq_n[gi];
      end
      assign eligible[gi] = pending[gi] & ~mask_q[gi] & ~(|isr_q[gi:0]);
    end
  endgenerate

  assign any_eligible = |eligible;

  // Two's-complement trick isolates the lowest set bit (highest priority).
  assign elig_lowest = eligible & (~eligible + NCH'(1));
  assign isr_lowest  = isr_q & (~isr_q + NCH'(1));

  // Encode the lowest eligible channel as a binary index for the vector.
  always_comb begin
    elig_idx = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        elig_idx = WW'(i);
      end
    end
  end

  // FSM next state, and the winner capture taken at the start of an acknowledge.
  always_comb begin
    state_d   = state_q;
    win_d     = win_q;
    win_vld_d = win_vld_q;
    capture   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ack) begin
          state_d   = ST_ACK;
          capture   = any_eligible;
          win_vld_d = any_eligible;
          if (any_eligible) begin
            win_d = elig_idx;
          end
        end
      end
      ST_ACK: begin
        if (!ack) begin
          state_d = ST_WAIT_END;
        end
      end
      ST_WAIT_END: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Flag next state. EOI clears before the capture sets the new flag.
  // A fresh edge beats the capture clear of the same channel.
  always_comb begin
    hist_d  = irq_n;
    mask_d  = mask_we ? mask_din : mask_q;
    isr_set = capture ? elig_lowest : '0;
    isr_d   = isr_q;
    if (eoi) begin
      isr_d = isr_d & ~isr_lowest;
    end
    isr_d  = isr_d | isr_set;
    pend_d = (pend_q & ~(isr_set & EDGE_MASK)) | fall;
  end

  assign win8 = 8'(win_q);

  // CPU-facing outputs. Reset gates them directly, so a level request cannot
  // pull int_n low during reset. It also frees the bus as soon as reset is asserted.
  always_comb begin
    int_n    = 1'b1;
    vec_oe   = 1'b0;
    vec_dout = 8'h00;
    if (!reset) begin
      if ((state_q == ST_IDLE) && any_eligible) begin
        int_n = 1'b0;
      end
      if ((state_q == ST_ACK) && ack) begin
        vec_oe = 1'b1;
        if (win_vld_q) begin
          vec_dout = VEC_BASE | (win8 << VEC_SHIFT);
        end else begin
          vec_dout = VEC_BASE | (NONE_IDX << VEC_SHIFT);
        end
      end
    end
  end

  // FSM state and captured winner.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      win_q     <= '0;
      win_vld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      win_q     <= win_d;
      win_vld_q <= win_vld_d;
    end
  end

  // Request, service, mask and edge-history registers.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      pend_q <= '0;
      isr_q  <= '0;
      mask_q <= '0;
      hist_q <= '1;
    end else begin
      pend_q <= pend_d;
      isr_q  <= isr_d;
      mask_q <= mask_d;
      hist_q <= hist_d;
    end
  end

  assign in_service = isr_q;

endmodule
